// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for an icache, a dcache and a dirty
// writeback FIFO. One command per cycle. The grant is combinational from the
// current requests and the registered state. A command counts as issued only
// when memory returns a nonzero transaction tag in the same cycle.

package mem_arbiter_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic valid;
        ADDR  addr;
    } I_ADDR_PACKET;

endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WB_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,

    input  I_ADDR_PACKET icache_req_addr,
    output logic         icache_req_accepted,

    input  I_ADDR_PACKET dcache_req_addr,
    output logic         dcache_req_accepted,

    input  logic         dcache_write_valid,
    input  I_ADDR_PACKET dcache_write_addr,
    input  MEM_BLOCK     dcache_write_data,
    output logic         wb_full,
    output logic         wb_overflow,

    output MEM_COMMAND   proc2mem_command,
    output ADDR          proc2mem_addr,
    output MEM_BLOCK     proc2mem_data,
    input  MEM_TAG       mem2proc_transaction_tag
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WB_DEPTH);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    // Block-aligned addresses: the low three bits select a byte within the block.
    localparam ADDR BLK_MASK = ~ADDR'(7);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_DRAIN  = 1'b1;

    // Registered state
    logic [0:0]          state_q,        state_d;
    logic [PTR_W-1:0]    head_q,         head_d;
    logic [PTR_W-1:0]    tail_q,         tail_d;
    logic [CNT_W-1:0]    count_q,        count_d;
    logic [STV_W-1:0]    starve_cnt_q,   starve_cnt_d;
    logic                overflow_q,     overflow_d;
    logic [WB_DEPTH-1:0] entry_valid_q,  entry_valid_d;

    // Writeback storage (address already block-aligned when written)
    ADDR      wb_addr_mem [WB_DEPTH];
    MEM_BLOCK wb_data_mem [WB_DEPTH];

    logic raw_hazard;
    logic grant_icache;
    logic grant_dcache;
    logic grant_store;
    logic tag_ok;
    logic pop;
    logic push_en;

    // The write packet carries its own valid bit, which duplicates
    // dcache_write_valid; only the strobe is used to push.
    logic unused_wr_pkt_valid;
    assign unused_wr_pkt_valid = dcache_write_addr.valid;

    assign tag_ok = (mem2proc_transaction_tag != '0);

    // RAW hazard: dcache read to a block that still sits in the writeback buffer.
    // Only entries already buffered are compared. An entry pushed this cycle
    // becomes visible to the check from the next cycle.
    // NOTE: every signal assigned in an always_comb gets a default at the top.
    // A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (entry_valid_q[i] &&
                (((wb_addr_mem[i] ^ dcache_req_addr.addr) & BLK_MASK) == '0)) begin
                raw_hazard = 1'b1;
            end
        end
        raw_hazard = raw_hazard & dcache_req_addr.valid;
    end

    // Arbitration. DRAIN issues only head stores. NORMAL priority is:
    // forced icache read, then a non-hazard dcache read, then an icache read,
    // then a store.
    always_comb begin
        grant_icache = 1'b0;
        grant_dcache = 1'b0;
        grant_store  = 1'b0;
        if (state_q == S_DRAIN) begin
            grant_store = (count_q != '0);
        end else if (icache_req_addr.valid && (starve_cnt_q == STV_LIMIT)) begin
            grant_icache = 1'b1;
        end else if (dcache_req_addr.valid && !raw_hazard) begin
            grant_dcache = 1'b1;
        end else if (icache_req_addr.valid) begin
            grant_icache = 1'b1;
        end else if (count_q != '0) begin
            grant_store = 1'b1;
        end
    end

    // Memory command outputs. These are forced idle while reset is high, so an
    // asserted reset silences the port without waiting for a clock edge.
    always_comb begin
        proc2mem_command    = MEM_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        icache_req_accepted = 1'b0;
        dcache_req_accepted = 1'b0;
        pop                 = 1'b0;
        if (!reset) begin
            if (grant_store) begin
                proc2mem_command = MEM_STORE;
                proc2mem_addr    = wb_addr_mem[head_q];
                proc2mem_data    = wb_data_mem[head_q];
                pop              = tag_ok;
            end else if (grant_dcache) begin
                proc2mem_command    = MEM_LOAD;
                proc2mem_addr       = dcache_req_addr.addr & BLK_MASK;
                dcache_req_accepted = tag_ok;
            end else if (grant_icache) begin
                proc2mem_command    = MEM_LOAD;
                proc2mem_addr       = icache_req_addr.addr & BLK_MASK;
                icache_req_accepted = tag_ok;
            end
        end
    end

    // Writeback FIFO bookkeeping. Pop is applied first, so a push at full
    // succeeds when the head store is accepted in the same cycle.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        entry_valid_d = entry_valid_q;
        overflow_d    = overflow_q;
        push_en       = 1'b0;

        if (pop) begin
            entry_valid_d[head_q] = 1'b0;
            head_d                = head_q + PTR_W'(1);
        end

        if (dcache_write_valid) begin
            if ((count_q != CNT_FULL) || pop) begin
                push_en               = 1'b1;
                entry_valid_d[tail_q] = 1'b1;
                tail_d                = tail_q + PTR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        case ({push_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter. It counts consecutive cycles in which a valid icache
    // request is not accepted, and saturates at the forcing threshold.
    always_comb begin
        starve_cnt_d = '0;
        if (icache_req_addr.valid && !icache_req_accepted) begin
            starve_cnt_d = (starve_cnt_q == STV_LIMIT) ? starve_cnt_q
                                                       : starve_cnt_q + STV_W'(1);
        end
    end

    // FSM next state. Decisions use the post-update count, so a buffer that
    // fills this cycle enters DRAIN immediately. A hazard whose entry is popped
    // this cycle does not cost an extra drain cycle.
    always_comb begin
        state_d = state_q;
        if (state_q == S_NORMAL) begin
            if ((count_d == CNT_FULL) || (raw_hazard && (count_d != '0))) begin
                state_d = S_DRAIN;
            end
        end else begin
            if (count_d == '0) begin
                state_d = S_NORMAL;
            end
        end
    end

    assign wb_full     = (count_q == CNT_FULL);
    assign wb_overflow = overflow_q;

    // Control state registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_NORMAL;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            starve_cnt_q  <= '0;
            overflow_q    <= 1'b0;
            entry_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            starve_cnt_q  <= starve_cnt_d;
            overflow_q    <= overflow_d;
            entry_valid_q <= entry_valid_d;
        end
    end

    // Writeback payload storage, written at the tail on an accepted push.
    // NOTE: the payload arrays are deliberately not reset. Occupancy is tracked
    // by count and the entry valid bits, which are reset, so stale payload is
    // never observed.
    always_ff @(posedge clock) begin
        if (push_en) begin
            wb_addr_mem[tail_q] <= dcache_write_addr.addr & BLK_MASK;
            wb_data_mem[tail_q] <= dcache_write_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Each driven cycle pushes its expected port values. A monitor pops and
// compares them mid-cycle, away from both clock edges.

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic         clock;
    logic         reset;
    I_ADDR_PACKET icache_req_addr;
    logic         icache_req_accepted;
    I_ADDR_PACKET dcache_req_addr;
    logic         dcache_req_accepted;
    logic         dcache_write_valid;
    I_ADDR_PACKET dcache_write_addr;
    MEM_BLOCK     dcache_write_data;
    logic         wb_full;
    logic         wb_overflow;
    MEM_COMMAND   proc2mem_command;
    ADDR          proc2mem_addr;
    MEM_BLOCK     proc2mem_data;
    MEM_TAG       mem2proc_transaction_tag;

    mem_arbiter #(.WB_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .icache_req_addr          (icache_req_addr),
        .icache_req_accepted      (icache_req_accepted),
        .dcache_req_addr          (dcache_req_addr),
        .dcache_req_accepted      (dcache_req_accepted),
        .dcache_write_valid       (dcache_write_valid),
        .dcache_write_addr        (dcache_write_addr),
        .dcache_write_data        (dcache_write_data),
        .wb_full                  (wb_full),
        .wb_overflow              (wb_overflow),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        wv;
        logic [31:0] wa;
        logic [63:0] wd;
        logic [3:0]  tag;
    } stim_t;

    typedef struct {
        int          id;
        MEM_COMMAND  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic        iacc;
        logic        dacc;
        logic        full;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    localparam logic [63:0] D0 = 64'h0300_0300_0300_0300;
    localparam logic [63:0] D1 = 64'h0308_0308_0308_0308;
    localparam logic [63:0] D2 = 64'h0400_DEAD_BEEF_0400;
    localparam logic [63:0] D3 = 64'h0600_0600_CAFE_0600;
    localparam logic [63:0] D4 = 64'h0700_0000_0000_0004;
    localparam logic [63:0] D5 = 64'h0708_0000_0000_0005;
    localparam logic [63:0] D6 = 64'h0710_0000_0000_0006;
    localparam logic [63:0] D7 = 64'h0718_0000_0000_0007;
    localparam logic [63:0] D8 = 64'h0800_0000_0000_0008;
    localparam logic [63:0] D9 = 64'h0808_0000_0000_0009;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic stim_t st(logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                                 logic wv, logic [31:0] wa, logic [63:0] wd, logic [3:0] tag);
        stim_t s;
        s.iv = iv; s.ia = ia; s.dv = dv; s.da = da;
        s.wv = wv; s.wa = wa; s.wd = wd; s.tag = tag;
        return s;
    endfunction

    function automatic exp_t ex(MEM_COMMAND cmd, logic [31:0] addr, logic [63:0] data,
                                logic iacc, logic dacc, logic full, logic ovf);
        exp_t e;
        e.id = 0; e.cmd = cmd; e.addr = addr; e.data = data;
        e.iacc = iacc; e.dacc = dacc; e.full = full; e.ovf = ovf;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        icache_req_addr          = '{valid: s.iv, addr: s.ia};
        dcache_req_addr          = '{valid: s.dv, addr: s.da};
        dcache_write_valid       = s.wv;
        dcache_write_addr        = '{valid: s.wv, addr: s.wa};
        dcache_write_data        = s.wd;
        mem2proc_transaction_tag = s.tag;
    endtask

    task automatic push_exp(input exp_t e);
        e.id = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the falling edge and log what the
    // ports must show during that cycle.
    task automatic cycle(input stim_t s, input exp_t e);
        @(negedge clock);
        #1;
        apply(s);
        push_exp(e);
    endtask

    // Monitor: compare mid-cycle, after inputs settle and before the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("step%0d cmd",  e.id), 64'(proc2mem_command),    64'(e.cmd));
                check($sformatf("step%0d addr", e.id), 64'(proc2mem_addr),       64'(e.addr));
                check($sformatf("step%0d data", e.id), proc2mem_data,            e.data);
                check($sformatf("step%0d iacc", e.id), 64'(icache_req_accepted), 64'(e.iacc));
                check($sformatf("step%0d dacc", e.id), 64'(dcache_req_accepted), 64'(e.dacc));
                check($sformatf("step%0d full", e.id), 64'(wb_full),             64'(e.full));
                check($sformatf("step%0d ovf",  e.id), 64'(wb_overflow),         64'(e.ovf));
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_cleared(input string tag);
        check({tag, " cmd"},  64'(proc2mem_command),    64'(MEM_NONE));
        check({tag, " addr"}, 64'(proc2mem_addr),       64'h0);
        check({tag, " data"}, proc2mem_data,            64'h0);
        check({tag, " iacc"}, 64'(icache_req_accepted), 64'h0);
        check({tag, " dacc"}, 64'(dcache_req_accepted), 64'h0);
        check({tag, " full"}, 64'(wb_full),             64'h0);
        check({tag, " ovf"},  64'(wb_overflow),         64'h0);
    endtask

    initial begin
        stim_t idle;
        stim_t both;
        idle = st(0, 0, 0, 0, 0, 0, 0, 4'd3);
        both = st(1, 32'h100, 1, 32'h200, 0, 0, 0, 4'd5);

        // Reset with live requests: all outputs must read as cleared.
        reset = 1'b1;
        apply(st(1, 32'h100, 1, 32'h200, 1, 32'h300, D0, 4'd3));
        #6;
        check_cleared("reset");
        @(negedge clock);
        #1;
        reset = 1'b0;
        apply(idle);

        // Simultaneous reads: the dcache wins.
        cycle(st(1, 32'h100, 1, 32'h200, 0, 0, 0, 4'd3), ex(MEM_LOAD, 32'h200, 0, 0, 1, 0, 0));
        cycle(idle, ex(MEM_NONE, 0, 0, 0, 0, 0, 0));
        // Zero tag: the command is presented but nothing is accepted.
        cycle(st(0, 0, 1, 32'h200, 0, 0, 0, 4'd0), ex(MEM_LOAD, 32'h200, 0, 0, 0, 0, 0));
        // An icache read alone, with an unaligned address.
        cycle(st(1, 32'h105, 0, 0, 0, 0, 0, 4'd2), ex(MEM_LOAD, 32'h100, 0, 1, 0, 0, 0));

        // Starvation: four denials, then a forced icache grant, then the pattern repeats.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) cycle(both, ex(MEM_LOAD, 32'h200, 0, 0, 1, 0, 0));
            cycle(both, ex(MEM_LOAD, 32'h100, 0, 1, 0, 0, 0));
        end
        cycle(idle, ex(MEM_NONE, 0, 0, 0, 0, 0, 0));

        // Fill and drain: DRAIN holds off reads and stores in FIFO order.
        cycle(st(0, 0, 0, 0, 1, 32'h300, D0, 4'd0), ex(MEM_NONE, 0, 0, 0, 0, 0, 0));
        cycle(st(0, 0, 0, 0, 1, 32'h308, D1, 4'd0), ex(MEM_STORE, 32'h300, D0, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h500, 0, 0, 0, 4'd0), ex(MEM_STORE, 32'h300, D0, 0, 0, 1, 0));
        cycle(st(0, 0, 1, 32'h500, 0, 0, 0, 4'd7), ex(MEM_STORE, 32'h300, D0, 0, 0, 1, 0));
        cycle(st(0, 0, 1, 32'h500, 0, 0, 0, 4'd7), ex(MEM_STORE, 32'h308, D1, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h500, 0, 0, 0, 4'd7), ex(MEM_LOAD, 32'h500, 0, 0, 1, 0, 0));

        // RAW hazard: the store goes first, then the load one cycle after it is accepted.
        cycle(st(0, 0, 0, 0, 1, 32'h400, D2, 4'd0), ex(MEM_NONE, 0, 0, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h404, 0, 0, 0, 4'd0), ex(MEM_STORE, 32'h400, D2, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h404, 0, 0, 0, 4'd9), ex(MEM_STORE, 32'h400, D2, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h404, 0, 0, 0, 4'd9), ex(MEM_LOAD, 32'h400, 0, 0, 1, 0, 0));

        // A same-cycle push is not yet visible to the hazard check.
        cycle(st(0, 0, 1, 32'h600, 1, 32'h600, D3, 4'd4), ex(MEM_LOAD, 32'h600, 0, 0, 1, 0, 0));
        cycle(st(0, 0, 1, 32'h600, 0, 0, 0, 4'd4), ex(MEM_STORE, 32'h600, D3, 0, 0, 0, 0));
        cycle(st(0, 0, 1, 32'h600, 0, 0, 0, 4'd4), ex(MEM_LOAD, 32'h600, 0, 0, 1, 0, 0));

        // Push plus pop at full, then a push dropped at full (overflow).
        cycle(st(0, 0, 0, 0, 1, 32'h700, D4, 4'd0), ex(MEM_NONE, 0, 0, 0, 0, 0, 0));
        cycle(st(0, 0, 0, 0, 1, 32'h708, D5, 4'd0), ex(MEM_STORE, 32'h700, D4, 0, 0, 0, 0));
        cycle(st(0, 0, 0, 0, 1, 32'h710, D6, 4'd6), ex(MEM_STORE, 32'h700, D4, 0, 0, 1, 0));
        cycle(st(0, 0, 0, 0, 1, 32'h718, D7, 4'd0), ex(MEM_STORE, 32'h708, D5, 0, 0, 1, 0));
        cycle(st(0, 0, 0, 0, 0, 0, 0, 4'd0),        ex(MEM_STORE, 32'h708, D5, 0, 0, 1, 1));
        cycle(st(0, 0, 0, 0, 0, 0, 0, 4'd6),        ex(MEM_STORE, 32'h708, D5, 0, 0, 1, 1));
        cycle(st(0, 0, 0, 0, 0, 0, 0, 4'd6),        ex(MEM_STORE, 32'h710, D6, 0, 0, 0, 1));
        cycle(st(0, 0, 0, 0, 0, 0, 0, 4'd6),        ex(MEM_NONE, 0, 0, 0, 0, 0, 1));

        // Asynchronous reset in the middle of DRAIN with two entries buffered.
        cycle(st(0, 0, 0, 0, 1, 32'h800, D8, 4'd0), ex(MEM_NONE, 0, 0, 0, 0, 0, 1));
        cycle(st(0, 0, 0, 0, 1, 32'h808, D9, 4'd0), ex(MEM_STORE, 32'h800, D8, 0, 0, 0, 1));
        cycle(st(0, 0, 1, 32'h900, 0, 0, 0, 4'd0),  ex(MEM_STORE, 32'h800, D8, 0, 0, 1, 1));
        @(negedge clock);
        #1;
        apply(st(0, 0, 1, 32'h900, 0, 0, 0, 4'd5));
        #1;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        @(negedge clock);
        #1;
        reset = 1'b0;
        push_exp(ex(MEM_LOAD, 32'h900, 0, 0, 1, 0, 0));
        cycle(st(0, 0, 0, 0, 0, 0, 0, 4'd5), ex(MEM_NONE, 0, 0, 0, 0, 0, 0));

        @(negedge clock);
        #5;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
